axi_master_access_gate: RTL and testbench

AXI_MASTER_ACCESS_GATE -- requirements
Module: axi_master_access_gate

---
 rtl/axi_master_access_gate.sv | 279 +++++++++++++++++++++++++++
 tb/tb_axi_master_access_gate.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_access_gate.sv
// AXI master-side access gate: forwards transactions that hit a permitted slave
// region, answers everything else locally with DECERR and logs the violation.
module axi_master_access_gate #(
   parameter int                 ID_W        = 4,
   parameter int                 DATA_W      = 32,
   parameter int                 NUM_SLV     = 7,
   parameter logic [31:0]        SLV_STRIDE  = 32'h2000,
   parameter logic [31:0]        SLV_SIZE    = 32'h1000,
   parameter logic [NUM_SLV-1:0] ACCESS_MASK = 7'b0011010,
   parameter int                 MAX_OUTST   = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [ID_W-1:0]     s_awid,
   input  logic [31:0]         s_awaddr,
   input  logic [3:0]          s_awlen,
   input  logic [2:0]          s_awsize,
   input  logic [1:0]          s_awburst,
   input  logic                s_awvalid,
   output logic                s_awready,
   input  logic [DATA_W-1:0]   s_wdata,
   input  logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_wlast,
   input  logic                s_wvalid,
   output logic                s_wready,
   output logic [5:0]          s_bid,
   output logic [1:0]          s_bresp,
   output logic                s_bvalid,
   input  logic                s_bready,
   input  logic [ID_W-1:0]     s_arid,
   input  logic [31:0]         s_araddr,
   input  logic [3:0]          s_arlen,
   input  logic [2:0]          s_arsize,
   input  logic [1:0]          s_arburst,
   input  logic                s_arvalid,
   output logic                s_arready,
   output logic [5:0]          s_rid,
   output logic [DATA_W-1:0]   s_rdata,
   output logic [1:0]          s_rresp,
   output logic                s_rlast,
   output logic                s_rvalid,
   input  logic                s_rready,
   output logic [ID_W-1:0]     m_awid,
   output logic [31:0]         m_awaddr,
   output logic [3:0]          m_awlen,
   output logic [2:0]          m_awsize,
   output logic [1:0]          m_awburst,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wlast,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [ID_W-1:0]     m_bid,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   output logic [ID_W-1:0]     m_arid,
   output logic [31:0]         m_araddr,
   output logic [3:0]          m_arlen,
   output logic [2:0]          m_arsize,
   output logic [1:0]          m_arburst,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [ID_W-1:0]     m_rid,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rlast,
   input  logic                m_rvalid,
   output logic                m_rready,
   output logic                viol_pulse,
   output logic [15:0]         viol_cnt,
   output logic [31:0]         viol_addr
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_SINK, W_BRESP} w_state_t;
   typedef enum logic {R_IDLE, R_GEN} r_state_t;

   w_state_t w_state_reg, w_state_next;
   r_state_t r_state_reg, r_state_next;
   logic [3:0]      wr_cnt_reg, rd_cnt_reg, rd_len_reg, beat_reg;
   logic [ID_W-1:0] awid_reg, arid_reg;
   logic [15:0]     viol_cnt_reg;
   logic [31:0]     viol_addr_reg;
   logic            viol_pulse_reg;

   function automatic logic [32:0] last_byte(input logic [31:0] a, input logic [3:0] len,
                                             input logic [2:0] size);
      logic [32:0] nbytes;
      nbytes = (33'(len) + 33'd1) << size;
      return {1'b0, a} + nbytes - 33'd1;
   endfunction

   // 33-bit difference so addresses below the base cannot wrap into the window
   function automatic logic in_window(input logic [31:0] a, input logic [31:0] base);
      logic [32:0] d;
      d = {1'b0, a} - {1'b0, base};
      return !d[32] && (d[31:0] < SLV_SIZE);
   endfunction

   logic [32:0]        aw_last, ar_last;
   logic [NUM_SLV-1:0] aw_hit, ar_hit;
   logic               aw_perm, ar_perm;

   assign aw_last = last_byte(s_awaddr, s_awlen, s_awsize);
   assign ar_last = last_byte(s_araddr, s_arlen, s_arsize);

   for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_region
      localparam logic [31:0] BASE = 32'(gi) * SLV_STRIDE;
      assign aw_hit[gi] = ACCESS_MASK[gi] && in_window(s_awaddr, BASE) && in_window(aw_last[31:0], BASE);
      assign ar_hit[gi] = ACCESS_MASK[gi] && in_window(s_araddr, BASE) && in_window(ar_last[31:0], BASE);
   end

   assign aw_perm = !aw_last[32] && (|aw_hit);
   assign ar_perm = !ar_last[32] && (|ar_hit);

   assign m_awid = s_awid;   assign m_awaddr = s_awaddr;   assign m_awlen = s_awlen;
   assign m_awsize = s_awsize; assign m_awburst = s_awburst;
   assign m_wdata = s_wdata; assign m_wstrb = s_wstrb;     assign m_wlast = s_wlast;
   assign m_arid = s_arid;   assign m_araddr = s_araddr;   assign m_arlen = s_arlen;
   assign m_arsize = s_arsize; assign m_arburst = s_arburst;

   logic s_awready_c, m_awvalid_c, s_wready_c, m_wvalid_c, s_bvalid_c, m_bready_c, aw_deny_hs;

   always_comb begin
      w_state_next = w_state_reg;
      s_awready_c  = 1'b0;
      m_awvalid_c  = 1'b0;
      s_wready_c   = 1'b0;
      m_wvalid_c   = 1'b0;
      s_bvalid_c   = m_bvalid;
      m_bready_c   = s_bready;
      s_bid        = 6'(m_bid);
      s_bresp      = m_bresp;
      aw_deny_hs   = 1'b0;
      case (w_state_reg)
         W_IDLE: begin
            if (aw_perm) begin
               if (wr_cnt_reg < MAX_CNT) begin
                  m_awvalid_c = s_awvalid;
                  s_awready_c = m_awready;
                  if (s_awvalid && m_awready) w_state_next = W_DATA;
               end
            end else if (wr_cnt_reg == 4'd0) begin
               s_awready_c = 1'b1;
               if (s_awvalid) begin
                  aw_deny_hs   = 1'b1;
                  w_state_next = W_SINK;
               end
            end
         end
         W_DATA: begin
            m_wvalid_c = s_wvalid;
            s_wready_c = m_wready;
            if (s_wvalid && m_wready && s_wlast) w_state_next = W_IDLE;
         end
         W_SINK: begin
            s_wready_c = 1'b1;
            if (s_wvalid && s_wlast) w_state_next = W_BRESP;
         end
         W_BRESP: begin
            s_bvalid_c = 1'b1;
            m_bready_c = 1'b0;
            s_bid      = 6'(awid_reg);
            s_bresp    = 2'b11;
            if (s_bready) w_state_next = W_IDLE;
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   logic s_arready_c, m_arvalid_c, s_rvalid_c, m_rready_c, ar_deny_hs;

   always_comb begin
      r_state_next = r_state_reg;
      s_arready_c  = 1'b0;
      m_arvalid_c  = 1'b0;
      s_rvalid_c   = m_rvalid;
      m_rready_c   = s_rready;
      s_rid        = 6'(m_rid);
      s_rdata      = m_rdata;
      s_rresp      = m_rresp;
      s_rlast      = m_rlast;
      ar_deny_hs   = 1'b0;
      case (r_state_reg)
         R_IDLE: begin
            if (ar_perm) begin
               if (rd_cnt_reg < MAX_CNT) begin
                  m_arvalid_c = s_arvalid;
                  s_arready_c = m_arready;
               end
            end else if (rd_cnt_reg == 4'd0) begin
               s_arready_c = 1'b1;
               if (s_arvalid) begin
                  ar_deny_hs   = 1'b1;
                  r_state_next = R_GEN;
               end
            end
         end
         R_GEN: begin
            s_rvalid_c = 1'b1;
            m_rready_c = 1'b0;
            s_rid      = 6'(arid_reg);
            s_rdata    = '0;
            s_rresp    = 2'b11;
            s_rlast    = (beat_reg == rd_len_reg);
            if (s_rready && beat_reg == rd_len_reg) r_state_next = R_IDLE;
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   // handshake qualifiers are gated by rstn so nothing leaks while in reset
   assign s_awready = s_awready_c & rstn;
   assign m_awvalid = m_awvalid_c & rstn;
   assign s_wready  = s_wready_c  & rstn;
   assign m_wvalid  = m_wvalid_c  & rstn;
   assign s_bvalid  = s_bvalid_c  & rstn;
   assign m_bready  = m_bready_c  & rstn;
   assign s_arready = s_arready_c & rstn;
   assign m_arvalid = m_arvalid_c & rstn;
   assign s_rvalid  = s_rvalid_c  & rstn;
   assign m_rready  = m_rready_c  & rstn;

   logic        wr_inc, wr_dec, rd_inc, rd_dec;
   logic [16:0] viol_sum;

   assign wr_inc   = m_awvalid && m_awready;
   assign wr_dec   = m_bvalid && m_bready;
   assign rd_inc   = m_arvalid && m_arready;
   assign rd_dec   = m_rvalid && m_rready && m_rlast;
   assign viol_sum = {1'b0, viol_cnt_reg} + 17'(aw_deny_hs) + 17'(ar_deny_hs);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         w_state_reg    <= W_IDLE;
         r_state_reg    <= R_IDLE;
         wr_cnt_reg     <= '0;
         rd_cnt_reg     <= '0;
         rd_len_reg     <= '0;
         beat_reg       <= '0;
         awid_reg       <= '0;
         arid_reg       <= '0;
         viol_cnt_reg   <= '0;
         viol_addr_reg  <= '0;
         viol_pulse_reg <= 1'b0;
      end else begin
         w_state_reg    <= w_state_next;
         r_state_reg    <= r_state_next;
         viol_pulse_reg <= aw_deny_hs | ar_deny_hs;
         viol_cnt_reg   <= viol_sum[16] ? 16'hFFFF : viol_sum[15:0];
         if (wr_inc && !wr_dec) wr_cnt_reg <= wr_cnt_reg + 4'd1;
         else if (!wr_inc && wr_dec) wr_cnt_reg <= wr_cnt_reg - 4'd1;
         if (rd_inc && !rd_dec) rd_cnt_reg <= rd_cnt_reg + 4'd1;
         else if (!rd_inc && rd_dec) rd_cnt_reg <= rd_cnt_reg - 4'd1;
         if (aw_deny_hs) begin
            awid_reg      <= s_awid;
            viol_addr_reg <= s_awaddr;
         end else if (ar_deny_hs) begin
            viol_addr_reg <= s_araddr;
         end
         if (ar_deny_hs) begin
            arid_reg   <= s_arid;
            rd_len_reg <= s_arlen;
            beat_reg   <= '0;
         end else if (r_state_reg == R_GEN && s_rready) begin
            beat_reg <= beat_reg + 4'd1;
         end
      end
   end

   assign viol_pulse = viol_pulse_reg;
   assign viol_cnt   = viol_cnt_reg;
   assign viol_addr  = viol_addr_reg;

endmodule

// File: tb/tb_axi_master_access_gate.sv
// Directed bench for axi_master_access_gate: region decode, DECERR write sink,
// DECERR read generation, outstanding limit, violation logging and reset.
module tb_axi_master_access_gate;
   localparam int ID_W = 4;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rstn;
   logic [ID_W-1:0] s_awid, s_arid, m_awid, m_arid, m_bid, m_rid;
   logic [31:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
   logic [3:0] s_awlen, s_arlen, m_awlen, m_arlen;
   logic [2:0] s_awsize, s_arsize, m_awsize, m_arsize;
   logic [1:0] s_awburst, s_arburst, m_awburst, m_arburst;
   logic s_awvalid, s_awready, m_awvalid, m_awready;
   logic [DATA_W-1:0] s_wdata, m_wdata, s_rdata, m_rdata;
   logic [DATA_W/8-1:0] s_wstrb, m_wstrb;
   logic s_wlast, s_wvalid, s_wready, m_wlast, m_wvalid, m_wready;
   logic [5:0] s_bid, s_rid;
   logic [1:0] s_bresp, m_bresp, s_rresp, m_rresp;
   logic s_bvalid, s_bready, m_bvalid, m_bready;
   logic s_arvalid, s_arready, m_arvalid, m_arready;
   logic s_rlast, s_rvalid, s_rready, m_rlast, m_rvalid, m_rready;
   logic viol_pulse;
   logic [15:0] viol_cnt;
   logic [31:0] viol_addr;

   int vec_cnt = 0;
   int err_cnt = 0;

   axi_master_access_gate dut (
      .clk(clk), .rstn(rstn),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .viol_pulse(viol_pulse), .viol_cnt(viol_cnt), .viol_addr(viol_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // drive an AW for half a cycle only, so no handshake is ever taken
   task automatic probe_aw(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                           input logic exp_fwd);
      s_awaddr = a; s_awlen = len; s_awsize = size; s_awvalid = 1'b1; m_awready = 1'b0;
      settle();
      chk($sformatf("aw_fwd_%h", a), 32'(m_awvalid), 32'(exp_fwd));
      s_awvalid = 1'b0;
      tick();
   endtask

   task automatic probe_ar(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                           input logic exp_fwd);
      s_araddr = a; s_arlen = len; s_arsize = size; s_arvalid = 1'b1; m_arready = 1'b0;
      settle();
      chk($sformatf("ar_fwd_%h", a), 32'(m_arvalid), 32'(exp_fwd));
      s_arvalid = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int beat;
      rstn = 1'b0;
      s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd2; s_awburst = 2'd1; s_awvalid = 1'b0;
      s_wdata = '0; s_wstrb = '1; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd2; s_arburst = 2'd1; s_arvalid = 1'b0;
      s_rready = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
      m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;

      // reset state, with upstream valids asserted
      tick(); tick();
      s_awvalid = 1'b1; s_arvalid = 1'b1; m_bvalid = 1'b1; m_rvalid = 1'b1; m_awready = 1'b1;
      settle();
      chk("rst_s_awready", 32'(s_awready), 0);
      chk("rst_m_awvalid", 32'(m_awvalid), 0);
      chk("rst_s_bvalid", 32'(s_bvalid), 0);
      chk("rst_s_rvalid", 32'(s_rvalid), 0);
      chk("rst_viol_cnt", 32'(viol_cnt), 0);
      s_awvalid = 1'b0; s_arvalid = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0; m_awready = 1'b0;
      tick();
      rstn = 1'b1;
      tick();

      // permitted write to 0x2000
      s_awid = 4'd5; s_awaddr = 32'h2000; s_awlen = 4'd0; s_awvalid = 1'b1; m_awready = 1'b1;
      settle();
      chk("pw_m_awvalid", 32'(m_awvalid), 1);
      chk("pw_s_awready", 32'(s_awready), 1);
      chk("pw_m_awaddr", m_awaddr, 32'h2000);
      tick();
      s_awvalid = 1'b0; m_awready = 1'b0;
      s_wvalid = 1'b1; s_wlast = 1'b1; s_wdata = 32'hDEADBEEF; m_wready = 1'b1;
      settle();
      chk("pw_m_wvalid", 32'(m_wvalid), 1);
      chk("pw_m_wdata", m_wdata, 32'hDEADBEEF);
      chk("pw_s_wready", 32'(s_wready), 1);
      tick();
      s_wvalid = 1'b0; s_wlast = 1'b0; m_wready = 1'b0;
      m_bvalid = 1'b1; m_bid = 4'd5; m_bresp = 2'b01; s_bready = 1'b1;
      settle();
      chk("pw_s_bvalid", 32'(s_bvalid), 1);
      chk("pw_s_bid", 32'(s_bid), 5);
      chk("pw_s_bresp", 32'(s_bresp), 1);
      chk("pw_m_bready", 32'(m_bready), 1);
      tick();
      m_bvalid = 1'b0; s_bready = 1'b0;
      settle();
      chk("pw_viol_cnt", 32'(viol_cnt), 0);
      tick();

      // denied write to 0x4000, len 3
      s_awid = 4'd9; s_awaddr = 32'h4000; s_awlen = 4'd3; s_awvalid = 1'b1; m_awready = 1'b1;
      settle();
      chk("dw_s_awready", 32'(s_awready), 1);
      chk("dw_m_awvalid", 32'(m_awvalid), 0);
      tick();
      s_awvalid = 1'b0; m_awready = 1'b0;
      settle();
      chk("dw_viol_pulse", 32'(viol_pulse), 1);
      chk("dw_viol_cnt", 32'(viol_cnt), 1);
      chk("dw_viol_addr", viol_addr, 32'h4000);
      for (int b = 0; b < 4; b++) begin
         s_wvalid = 1'b1; s_wlast = (b == 3); m_wready = 1'b0;
         settle();
         chk($sformatf("dw_sink_wready_%0d", b), 32'(s_wready), 1);
         chk($sformatf("dw_sink_mwvalid_%0d", b), 32'(m_wvalid | m_awvalid), 0);
         tick();
      end
      s_wvalid = 1'b0; s_wlast = 1'b0; m_bvalid = 1'b1; s_bready = 1'b0;
      settle();
      chk("dw_s_bvalid", 32'(s_bvalid), 1);
      chk("dw_s_bresp", 32'(s_bresp), 3);
      chk("dw_s_bid", 32'(s_bid), 9);
      chk("dw_m_bready", 32'(m_bready), 0);
      chk("dw_pulse_gone", 32'(viol_pulse), 0);
      tick();
      settle();
      chk("dw_bvalid_hold", 32'(s_bvalid), 1);
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0; m_bvalid = 1'b0;
      settle();
      chk("dw_b_done", 32'(s_bvalid), 0);
      tick();

      // denied read to 0x0000, len 2, rready toggling
      s_arid = 4'd3; s_araddr = 32'h0; s_arlen = 4'd2; s_arvalid = 1'b1; m_arready = 1'b1;
      settle();
      chk("dr_s_arready", 32'(s_arready), 1);
      chk("dr_m_arvalid", 32'(m_arvalid), 0);
      tick();
      s_arvalid = 1'b0; m_arready = 1'b0;
      beat = 0;
      for (int c = 0; c < 12 && beat < 3; c++) begin
         s_rready = c[0];
         settle();
         chk("dr_rvalid", 32'(s_rvalid), 1);
         chk("dr_rdata", s_rdata, 0);
         chk("dr_rresp", 32'(s_rresp), 3);
         chk("dr_rid", 32'(s_rid), 3);
         chk($sformatf("dr_rlast_b%0d", beat), 32'(s_rlast), 32'(beat == 2));
         chk("dr_arready", 32'(s_arready), 0);
         if (s_rready) beat++;
         tick();
      end
      s_rready = 1'b0;
      settle();
      chk("dr_beats", 32'(beat), 3);
      chk("dr_done", 32'(s_rvalid), 0);
      chk("dr_viol_cnt", 32'(viol_cnt), 2);
      tick();

      // region decode table
      probe_aw(32'h2000, 4'd0, 3'd2, 1'b1);
      probe_aw(32'h2FF8, 4'd3, 3'd2, 1'b0);
      probe_aw(32'h2FF0, 4'd3, 3'd2, 1'b1);
      probe_aw(32'h2FFF, 4'd0, 3'd0, 1'b1);
      probe_aw(32'h3000, 4'd0, 3'd2, 1'b0);
      probe_aw(32'h6000, 4'd0, 3'd2, 1'b1);
      probe_aw(32'h8000, 4'd0, 3'd2, 1'b1);
      probe_aw(32'hA000, 4'd0, 3'd2, 1'b0);
      probe_aw(32'hE000, 4'd0, 3'd2, 1'b0);
      probe_aw(32'hFFFF_FFF8, 4'd1, 3'd3, 1'b0);
      probe_ar(32'h6100, 4'd7, 3'd2, 1'b1);
      probe_ar(32'hC000, 4'd0, 3'd2, 1'b0);

      // burst crossing a region boundary on the read side
      s_arid = 4'd7; s_araddr = 32'h2FF8; s_arlen = 4'd3; s_arsize = 3'd2; s_arvalid = 1'b1; m_arready = 1'b1;
      settle();
      chk("xr_m_arvalid", 32'(m_arvalid), 0);
      chk("xr_s_arready", 32'(s_arready), 1);
      tick();
      s_arvalid = 1'b0; m_arready = 1'b0; s_rready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         settle();
         chk($sformatf("xr_rresp_%0d", b), 32'(s_rresp), 3);
         chk($sformatf("xr_rlast_%0d", b), 32'(s_rlast), 32'(b == 3));
         tick();
      end
      s_rready = 1'b0;
      settle();
      chk("xr_viol_addr", viol_addr, 32'h2FF8);
      chk("xr_viol_cnt", 32'(viol_cnt), 3);
      tick();

      // outstanding limit: 8 permitted reads, 9th stalls, denied AR waits
      m_arready = 1'b1; s_arlen = 4'd0;
      for (int k = 0; k < 8; k++) begin
         s_arid = 4'(k); s_araddr = 32'h2000 + 32'(k * 16); s_arvalid = 1'b1;
         settle();
         chk($sformatf("os_m_arvalid_%0d", k), 32'(m_arvalid), 1);
         chk($sformatf("os_s_arready_%0d", k), 32'(s_arready), 1);
         tick();
      end
      s_araddr = 32'h2100;
      settle();
      chk("os_9th_arready", 32'(s_arready), 0);
      chk("os_9th_m_arvalid", 32'(m_arvalid), 0);
      s_araddr = 32'h0; s_arid = 4'hA;
      #1;
      chk("os_deny_blocked", 32'(s_arready), 0);
      tick();
      s_rready = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b1;
      for (int k = 0; k < 8; k++) begin
         m_rid = 4'(k); m_rdata = 32'(k) * 32'h11;
         settle();
         chk($sformatf("os_wait_arready_%0d", k), 32'(s_arready), 0);
         chk($sformatf("os_rdata_%0d", k), s_rdata, 32'(k) * 32'h11);
         chk($sformatf("os_rid_%0d", k), 32'(s_rid), 32'(k));
         tick();
      end
      m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 1'b0;
      settle();
      chk("os_deny_accept", 32'(s_arready), 1);
      tick();
      s_arvalid = 1'b0; m_arready = 1'b0; s_rready = 1'b1;
      settle();
      chk("os_gen_rid", 32'(s_rid), 32'hA);
      chk("os_gen_rlast", 32'(s_rlast), 1);
      chk("os_gen_rresp", 32'(s_rresp), 3);
      tick();
      s_rready = 1'b0;
      settle();
      chk("os_viol_cnt", 32'(viol_cnt), 4);
      tick();

      // denied AW and AR in the same cycle
      s_awid = 4'd1; s_awaddr = 32'h4000; s_awlen = 4'd0; s_awvalid = 1'b1;
      s_arid = 4'd2; s_araddr = 32'h0; s_arlen = 4'd0; s_arvalid = 1'b1;
      settle();
      chk("sim_s_awready", 32'(s_awready), 1);
      chk("sim_s_arready", 32'(s_arready), 1);
      tick();
      s_awvalid = 1'b0; s_arvalid = 1'b0;
      settle();
      chk("sim_viol_cnt", 32'(viol_cnt), 6);
      chk("sim_viol_addr", viol_addr, 32'h4000);
      chk("sim_viol_pulse", 32'(viol_pulse), 1);
      s_wvalid = 1'b1; s_wlast = 1'b1; s_rready = 1'b1;
      #1;
      chk("sim_rid", 32'(s_rid), 2);
      tick();
      s_wvalid = 1'b0; s_wlast = 1'b0; s_rready = 1'b0; s_bready = 1'b1;
      settle();
      chk("sim_bid", 32'(s_bid), 1);
      chk("sim_bvalid", 32'(s_bvalid), 1);
      tick();
      s_bready = 1'b0;
      tick();

      // reset while sinking write beats
      s_awid = 4'd4; s_awaddr = 32'h4000; s_awlen = 4'd3; s_awvalid = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b1; s_wlast = 1'b0;
      settle();
      chk("rs_sinking", 32'(s_wready), 1);
      tick();
      rstn = 1'b0;
      settle();
      chk("rs_in_reset_wready", 32'(s_wready), 0);
      tick();
      rstn = 1'b1;
      settle();
      chk("rs_idle_wready", 32'(s_wready), 0);
      chk("rs_bvalid", 32'(s_bvalid), 0);
      chk("rs_rvalid", 32'(s_rvalid), 0);
      chk("rs_viol_cnt", 32'(viol_cnt), 0);
      chk("rs_viol_addr", viol_addr, 0);
      chk("rs_viol_pulse", 32'(viol_pulse), 0);
      s_wvalid = 1'b0;
      tick();
      probe_aw(32'h2000, 4'd0, 3'd2, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
